// File: rtl/ctc_mod.sv
// rtl/ctc_mod.sv - parametrised modulo-N up/down counter with load, one-shot halt and terminal-count flags

module ctc_mod #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             one_shot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             done
);

   // Reject moduli that cannot be represented or that give a degenerate counter.
   if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $error("ctc_mod: MODULUS must lie in 2..2**WIDTH");
   end

   // Highest legal count value; MODULUS may equal 2**WIDTH, so MODULUS-1 always fits in WIDTH bits.
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_done;

   logic [WIDTH-1:0] w_load_clamped;
   logic             w_at_term;
   logic [WIDTH-1:0] w_wrap_val;
   logic [WIDTH-1:0] w_step_val;

   // Next-value helpers: load clamp, terminal detect for the direction sampled this edge, wrap and step values.
   always_comb begin
      w_load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;
      w_at_term      = up_dn ? (r_count == MAX_CNT) : (r_count == '0);
      w_wrap_val     = up_dn ? '0 : MAX_CNT;
      w_step_val     = up_dn ? (r_count + 1'b1) : (r_count - 1'b1);
   end

   // Counter FSM: reset > load > enabled step; RUN counts and wraps or halts, HALT waits for load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
         r_count <= '0;
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
      end else if (load) begin
         r_state <= ST_RUN;
         r_count <= w_load_clamped;
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_tc <= 1'b0;
               if (en) begin
                  if (w_at_term) begin
                     r_tc <= 1'b1;
                     if (one_shot) begin
                        // Terminal value is already on count; park here until a load.
                        r_state <= ST_HALT;
                        r_done  <= 1'b1;
                     end else begin
                        r_count <= w_wrap_val;
                     end
                  end else begin
                     r_count <= w_step_val;
                  end
               end
            end
            ST_HALT: begin
               r_tc   <= 1'b0;
               r_done <= 1'b1;
            end
            default: begin
               r_state <= ST_RUN;
               r_tc    <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign done  = r_done;

endmodule

// File: tb/tb_ctc_mod.sv
// tb/tb_ctc_mod.sv - directed self-checking bench for ctc_mod (default and MODULUS=5 instances)

module tb_ctc_mod;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic       up_dn;
   logic       one_shot;
   logic       load;
   logic [2:0] load_val;

   logic [2:0] count_a;
   logic       tc_a;
   logic       done_a;
   logic [2:0] count_b;
   logic       tc_b;
   logic       done_b;

   int checks;
   int failures;

   ctc_mod #(.WIDTH(3), .MODULUS(8)) u_dut_a (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .up_dn    (up_dn),
      .one_shot (one_shot),
      .load     (load),
      .load_val (load_val),
      .count    (count_a),
      .tc       (tc_a),
      .done     (done_a)
   );

   ctc_mod #(.WIDTH(3), .MODULUS(5)) u_dut_b (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .up_dn    (up_dn),
      .one_shot (one_shot),
      .load     (load),
      .load_val (load_val),
      .count    (count_b),
      .tc       (tc_b),
      .done     (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      en       = 1'b0;
      up_dn    = 1'b0;
      one_shot = 1'b0;
      load     = 1'b0;
      load_val = 3'd0;
      #2;
      checks++;
      if ({count_a, tc_a, done_a} !== 5'b000_0_0) begin
         failures++;
         $display("FAIL reset_a: got count=%0d tc=%0b done=%0b want 0 0 0", count_a, tc_a, done_a);
      end
      checks++;
      if ({count_b, tc_b, done_b} !== 5'b000_0_0) begin
         failures++;
         $display("FAIL reset_b: got count=%0d tc=%0b done=%0b want 0 0 0", count_b, tc_b, done_b);
      end
      tick();
      checks++;
      if (count_a !== 3'd0) begin
         failures++;
         $display("FAIL reset_hold: got count=%0d want 0", count_a);
      end
   endtask

   task automatic test_legacy();
      logic [2:0] exp_cnt [10] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
      logic       exp_tc  [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      reset_n = 1'b1;
      en      = 1'b1;
      up_dn   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (count_a !== exp_cnt[i] || tc_a !== exp_tc[i]) begin
            failures++;
            $display("FAIL legacy[%0d]: got count=%0d tc=%0b want count=%0d tc=%0b",
                     i, count_a, tc_a, exp_cnt[i], exp_tc[i]);
         end
      end
   endtask

   task automatic test_up_mod5();
      logic [2:0] exp_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      logic       exp_tc  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      en       = 1'b0;
      load_val = 3'd0;
      load     = 1'b1;
      tick();
      load  = 1'b0;
      checks++;
      if (count_b !== 3'd0 || tc_b !== 1'b0) begin
         failures++;
         $display("FAIL up5_load: got count=%0d tc=%0b want 0 0", count_b, tc_b);
      end
      en    = 1'b1;
      up_dn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (count_b !== exp_cnt[i] || tc_b !== exp_tc[i]) begin
            failures++;
            $display("FAIL up5[%0d]: got count=%0d tc=%0b want count=%0d tc=%0b",
                     i, count_b, tc_b, exp_cnt[i], exp_tc[i]);
         end
      end
   endtask

   task automatic test_one_shot();
      logic [2:0] exp_cnt  [6] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
      logic       exp_tc   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       exp_done [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      en       = 1'b0;
      up_dn    = 1'b0;
      load_val = 3'd3;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      en       = 1'b1;
      one_shot = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (count_a !== exp_cnt[i] || tc_a !== exp_tc[i] || done_a !== exp_done[i]) begin
            failures++;
            $display("FAIL oneshot[%0d]: got count=%0d tc=%0b done=%0b want count=%0d tc=%0b done=%0b",
                     i, count_a, tc_a, done_a, exp_cnt[i], exp_tc[i], exp_done[i]);
         end
      end
      // Dropping one_shot and flipping direction must not leave HALT.
      one_shot = 1'b0;
      up_dn    = 1'b1;
      tick();
      tick();
      checks++;
      if (count_a !== 3'd0 || tc_a !== 1'b0 || done_a !== 1'b1) begin
         failures++;
         $display("FAIL halt_sticky: got count=%0d tc=%0b done=%0b want 0 0 1", count_a, tc_a, done_a);
      end
      en       = 1'b0;
      up_dn    = 1'b0;
      load_val = 3'd2;
      load     = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (count_a !== 3'd2 || done_a !== 1'b0 || tc_a !== 1'b0) begin
         failures++;
         $display("FAIL halt_exit_load: got count=%0d tc=%0b done=%0b want 2 0 0", count_a, tc_a, done_a);
      end
   endtask

   task automatic test_one_shot_at_term();
      en       = 1'b0;
      load_val = 3'd4;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      en       = 1'b1;
      up_dn    = 1'b1;
      one_shot = 1'b1;
      tick();
      checks++;
      if (count_b !== 3'd4 || tc_b !== 1'b1 || done_b !== 1'b1) begin
         failures++;
         $display("FAIL oneshot_at_term: got count=%0d tc=%0b done=%0b want 4 1 1", count_b, tc_b, done_b);
      end
      en       = 1'b0;
      one_shot = 1'b0;
   endtask

   task automatic test_load_clamp();
      load_val = 3'd6;
      load     = 1'b1;
      en       = 1'b1;
      up_dn    = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (count_b !== 3'd4 || tc_b !== 1'b0 || done_b !== 1'b0) begin
         failures++;
         $display("FAIL load_clamp: got count=%0d tc=%0b done=%0b want 4 0 0", count_b, tc_b, done_b);
      end
      checks++;
      if (count_a !== 3'd6) begin
         failures++;
         $display("FAIL load_noclamp: got count=%0d want 6", count_a);
      end
      up_dn = 1'b0;
      tick();
      checks++;
      if (count_b !== 3'd3 || tc_b !== 1'b0) begin
         failures++;
         $display("FAIL dir_flip: got count=%0d tc=%0b want 3 0", count_b, tc_b);
      end
      en = 1'b0;
   endtask

   task automatic test_async_reset();
      en       = 1'b0;
      up_dn    = 1'b0;
      one_shot = 1'b0;
      load_val = 3'd5;
      load     = 1'b1;
      tick();
      load = 1'b0;
      en   = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (count_a !== 3'd0 || tc_a !== 1'b0 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got count=%0d tc=%0b done=%0b want 0 0 0", count_a, tc_a, done_a);
      end
      tick();
      reset_n  = 1'b1;
      en       = 1'b0;
      load_val = 3'd0;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      en       = 1'b1;
      one_shot = 1'b1;
      tick();
      checks++;
      if (done_a !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_halt: got done=%0b want 1", done_a);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (count_a !== 3'd0 || tc_a !== 1'b0 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_halt: got count=%0d tc=%0b done=%0b want 0 0 0", count_a, tc_a, done_a);
      end
      tick();
      reset_n  = 1'b1;
      one_shot = 1'b0;
      en       = 1'b1;
      up_dn    = 1'b0;
      tick();
      checks++;
      if (count_a !== 3'd7 || tc_a !== 1'b1 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_to_run: got count=%0d tc=%0b done=%0b want 7 1 0", count_a, tc_a, done_a);
      end
   endtask

   task automatic test_en_gating();
      logic       en_seq  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0] exp_cnt [4] = '{3'd1, 3'd1, 3'd1, 3'd0};
      en       = 1'b0;
      up_dn    = 1'b0;
      one_shot = 1'b0;
      load_val = 3'd2;
      load     = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en = en_seq[i];
         tick();
         checks++;
         if (count_a !== exp_cnt[i] || tc_a !== 1'b0) begin
            failures++;
            $display("FAIL en_gate[%0d]: got count=%0d tc=%0b want count=%0d tc=0",
                     i, count_a, tc_a, exp_cnt[i]);
         end
      end
      en = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_legacy();
      test_up_mod5();
      test_one_shot();
      test_one_shot_at_term();
      test_load_clamp();
      test_async_reset();
      test_en_gating();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
